// File: rtl/mc_control.sv
// mc_control: multicycle MIPS Moore control FSM with ALU decode and retired-instruction counter
// Ports: clk/rst_n; opc, funct, zero from datapath; iord, irwrite, memwrite, memtoreg, regdst,
// regwrite, alusrca, alusrcb, pcsrc, pcen, alucontrol to datapath; illegal pulse; retired count.
module mc_control #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opc,
  input  logic [5:0]       funct,
  input  logic             zero,
  output logic             iord,
  output logic             irwrite,
  output logic             memwrite,
  output logic             memtoreg,
  output logic             regdst,
  output logic             regwrite,
  output logic             alusrca,
  output logic [1:0]       alusrcb,
  output logic [1:0]       pcsrc,
  output logic             pcen,
  output logic [2:0]       alucontrol,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);
  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP
  } state_t;
  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100, OP_ADDI = 6'b001000, OP_J = 6'b000010;
  localparam logic [1:0] AOP_NONE = 2'd0, AOP_ADD = 2'd1, AOP_SUB = 2'd2, AOP_FN = 2'd3;
  state_t           r_state, w_next;
  logic [CNT_W-1:0] r_retired;
  logic [1:0]       w_aluop;
  logic             w_pcwrite, w_branch, w_bad_opc, w_bad_fn, w_done;
  logic [2:0]       w_fdec;
  assign w_bad_opc = !(opc inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J});
  assign w_bad_fn  = !(funct inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010});
  assign w_fdec = funct == 6'b100010 ? 3'b110 :
                  funct == 6'b100100 ? 3'b000 :
                  funct == 6'b100101 ? 3'b001 :
                  funct == 6'b101010 ? 3'b111 : 3'b010;
  assign alucontrol = w_aluop == AOP_ADD ? 3'b010 :
                      w_aluop == AOP_SUB ? 3'b110 :
                      w_aluop == AOP_FN  ? w_fdec : 3'b000;
  assign pcen    = w_pcwrite | (w_branch & zero);
  assign illegal = (r_state == DECODE && w_bad_opc) || (r_state == EXEC && w_bad_fn);
  // Every instruction-completing state returns to FETCH unconditionally
  assign w_done  = r_state inside {MEMWB, MEMWR, ALUWB, BRANCH, ADDIWB, JUMP};
  assign retired = r_retired;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= FETCH;
      r_retired <= '0;
    end else begin
      r_state <= w_next;
      if (w_done) r_retired <= r_retired + 1'b1;
    end
  end
  always_comb begin
    w_next    = FETCH;
    iord      = 1'b0;
    irwrite   = 1'b0;
    memwrite  = 1'b0;
    memtoreg  = 1'b0;
    regdst    = 1'b0;
    regwrite  = 1'b0;
    alusrca   = 1'b0;
    alusrcb   = 2'b00;
    pcsrc     = 2'b00;
    w_aluop   = AOP_NONE;
    w_pcwrite = 1'b0;
    w_branch  = 1'b0;
    case (r_state)
      FETCH: begin
        irwrite   = 1'b1;
        alusrcb   = 2'b01;
        w_aluop   = AOP_ADD;
        w_pcwrite = 1'b1;
        w_next    = DECODE;
      end
      DECODE: begin
        alusrcb = 2'b11;
        w_aluop = AOP_ADD;
        w_next  = (opc == OP_LW || opc == OP_SW) ? MEMADR :
                  opc == OP_R    ? EXEC   :
                  opc == OP_BEQ  ? BRANCH :
                  opc == OP_ADDI ? ADDIEX :
                  opc == OP_J    ? JUMP   : FETCH;
      end
      MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        w_aluop = AOP_ADD;
        w_next  = opc == OP_LW ? MEMRD : MEMWR;
      end
      MEMRD: begin
        iord   = 1'b1;
        w_next = MEMWB;
      end
      MEMWB: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
      end
      MEMWR: begin
        iord     = 1'b1;
        memwrite = 1'b1;
      end
      EXEC: begin
        alusrca = 1'b1;
        w_aluop = AOP_FN;
        w_next  = ALUWB;
      end
      ALUWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
      end
      BRANCH: begin
        alusrca  = 1'b1;
        w_aluop  = AOP_SUB;
        pcsrc    = 2'b01;
        w_branch = 1'b1;
      end
      ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        w_aluop = AOP_ADD;
        w_next  = ADDIWB;
      end
      ADDIWB: regwrite = 1'b1;
      JUMP: begin
        pcsrc     = 2'b10;
        w_pcwrite = 1'b1;
      end
      default: w_next = FETCH;
    endcase
  end
endmodule

// File: tb/tb_mc_control.sv
// tb_mc_control: randomized self-checking bench for mc_control against a per-instruction step model
module tb_mc_control;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [5:0]  opc = '0, funct = '0;
  logic        zero = 1'b0;
  logic        iord, irwrite, memwrite, memtoreg, regdst, regwrite, alusrca, pcen, illegal;
  logic [1:0]  alusrcb, pcsrc;
  logic [2:0]  alucontrol;
  logic [15:0] retired;
  logic        iord4, irwrite4, memwrite4, memtoreg4, regdst4, regwrite4, alusrca4, pcen4, illegal4;
  logic [1:0]  alusrcb4, pcsrc4;
  logic [2:0]  alucontrol4;
  logic [3:0]  retired4;
  int          n_chk = 0, n_pass = 0, cnt = 0;
  localparam int S_F = 0, S_D = 1, S_MA = 2, S_MR = 3, S_MWB = 4, S_MWR = 5, S_EX = 6;
  localparam int S_AWB = 7, S_BR = 8, S_AE = 9, S_IWB = 10, S_J = 11;
  always #5 clk = ~clk;
  mc_control #(.CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .opc(opc), .funct(funct), .zero(zero), .iord(iord),
    .irwrite(irwrite), .memwrite(memwrite), .memtoreg(memtoreg), .regdst(regdst),
    .regwrite(regwrite), .alusrca(alusrca), .alusrcb(alusrcb), .pcsrc(pcsrc), .pcen(pcen),
    .alucontrol(alucontrol), .illegal(illegal), .retired(retired)
  );
  mc_control #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .opc(opc), .funct(funct), .zero(zero), .iord(iord4),
    .irwrite(irwrite4), .memwrite(memwrite4), .memtoreg(memtoreg4), .regdst(regdst4),
    .regwrite(regwrite4), .alusrca(alusrca4), .alusrcb(alusrcb4), .pcsrc(pcsrc4), .pcen(pcen4),
    .alucontrol(alucontrol4), .illegal(illegal4), .retired(retired4)
  );
  logic [15:0] obs;
  assign obs = {iord, irwrite, memwrite, memtoreg, regdst, regwrite, alusrca, alusrcb, pcsrc,
                pcen, alucontrol, illegal};
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  function automatic logic [2:0] fn_op(input logic [5:0] fn);
    case (fn)
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction
  function automatic logic fn_bad(input logic [5:0] fn);
    return !(fn inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010});
  endfunction
  function automatic logic op_bad(input logic [5:0] op);
    return !(op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010});
  endfunction
  function automatic logic [15:0] exp_vec(input int s, input logic [5:0] op, input logic [5:0] fn,
                                          input logic z);
    logic io = 0, irw = 0, mw = 0, m2r = 0, rd = 0, rw = 0, sa = 0, pe = 0, il = 0;
    logic [1:0] sb = 0, ps = 0;
    logic [2:0] ac = 0;
    case (s)
      S_F:   begin irw = 1; sb = 2'b01; ac = 3'b010; pe = 1; end
      S_D:   begin sb = 2'b11; ac = 3'b010; il = op_bad(op); end
      S_MA:  begin sa = 1; sb = 2'b10; ac = 3'b010; end
      S_MR:  io = 1;
      S_MWB: begin m2r = 1; rw = 1; end
      S_MWR: begin io = 1; mw = 1; end
      S_EX:  begin sa = 1; ac = fn_op(fn); il = fn_bad(fn); end
      S_AWB: begin rd = 1; rw = 1; end
      S_BR:  begin sa = 1; ac = 3'b110; ps = 2'b01; pe = z; end
      S_AE:  begin sa = 1; sb = 2'b10; ac = 3'b010; end
      S_IWB: rw = 1;
      S_J:   begin ps = 2'b10; pe = 1; end
      default: ;
    endcase
    return {io, irw, mw, m2r, rd, rw, sa, sb, ps, pe, ac, il};
  endfunction
  task automatic check_now(input int s);
    chk($sformatf("ctl s%0d opc=%b fn=%b z=%b", s, opc, funct, zero), 32'(obs),
        32'(exp_vec(s, opc, funct, zero)));
    chk("retired16", 32'(retired), 32'(cnt & 16'hFFFF));
    chk("retired4", 32'(retired4), 32'(cnt & 4'hF));
  endtask
  // Runs each step of one instruction; entered and left just after a falling edge
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int max_steps);
    int steps[$];
    case (op)
      6'b100011: steps = '{S_F, S_D, S_MA, S_MR, S_MWB};
      6'b101011: steps = '{S_F, S_D, S_MA, S_MWR};
      6'b000000: steps = '{S_F, S_D, S_EX, S_AWB};
      6'b000100: steps = '{S_F, S_D, S_BR};
      6'b001000: steps = '{S_F, S_D, S_AE, S_IWB};
      6'b000010: steps = '{S_F, S_D, S_J};
      default:   steps = '{S_F, S_D};
    endcase
    opc = op;
    funct = fn;
    for (int i = 0; i < steps.size() && i < max_steps; i++) begin
      zero = 1'($urandom);
      #1 check_now(steps[i]);
      zero = ~zero;
      #1 check_now(steps[i]);
      @(negedge clk);
    end
    if (max_steps >= steps.size() && !op_bad(op)) cnt++;
  endtask
  task automatic rand_instr();
    logic [5:0] ops[7];
    logic [5:0] fns[6];
    logic [5:0] op, fn;
    ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010, 6'b000000};
    fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000000};
    op = $urandom_range(0, 7) == 7 ? 6'($urandom) : ops[$urandom_range(0, 6)];
    fn = $urandom_range(0, 3) == 0 ? 6'($urandom) : fns[$urandom_range(0, 5)];
    run_instr(op, fn, 99);
  endtask
  initial begin
    repeat (3) begin
      @(negedge clk);
      opc = 6'($urandom);
      #1 check_now(S_F);
    end
    rst_n = 1'b1;
    run_instr(6'b100011, 6'b000000, 99);
    run_instr(6'b000000, 6'b100010, 99);
    run_instr(6'b000100, 6'b000000, 99);
    run_instr(6'b111111, 6'b000000, 99);
    run_instr(6'b000000, 6'b000000, 99);
    repeat (60) rand_instr();
    run_instr(6'b100011, 6'b100000, 3);
    #2 rst_n = 1'b0;
    cnt = 0;
    #1 check_now(S_F);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (16) run_instr(6'b000010, 6'b000000, 99);
    #1 chk("wrap4", 32'(retired4), 32'd0);
    chk("wrap16", 32'(retired), 32'd16);
    repeat (60) rand_instr();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
